// File: rtl/sync_group_randomizer.sv
// Transport-stream energy dispersal: a 15-stage PRBS (1+x^14+x^15) whitens packet payload in groups of
// GROUP_PKTS packets, with the group-start sync inverted as the receive-side alignment marker.
module sync_group_randomizer #(
    parameter int          GROUP_PKTS = 8,
    parameter int          PKT_LEN    = 188,
    parameter logic [14:0] INIT_SEED  = 15'b000000010101001
) (
    input  logic       iClk,
    input  logic       iClrn,
    input  logic       iValid,
    input  logic [7:0] iData,
    input  logic       iPSync,
    input  logic       iCheck,
    input  logic       iMode,
    input  logic       iBypass,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oPSync,
    output logic       oCheck,
    output logic       oGroupStart,
    output logic       oSyncErr
);

    localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN - 1);
    localparam logic [3:0] LAST_PKT  = 4'(GROUP_PKTS - 1);
    localparam logic [7:0] GS_MARK   = 8'hB8;

    // Eight generator steps at once; bits come out MSB first.
    function automatic logic [7:0] keystream(input logic [15:1] s);
        return s[15:8] ^ s[14:7];
    endfunction

    logic [15:1] prbs, prbs_nxt;
    logic [7:0]  byte_cnt, byte_nxt;
    logic [3:0]  pkt_cnt, pkt_nxt;
    logic [7:0]  data_p1, data_nxt;
    logic        vld_p1, psync_p1, check_p1, gstart_p1, err_p1;
    logic        gstart_nxt, err_nxt;

    logic [7:0]  ks;
    logic        is_sync, flywheel, realign, gs_pos, force_gs, group_start, gs_miss;

    always_comb begin
        ks          = keystream(prbs);
        flywheel    = (byte_cnt == 8'd0) && !iPSync;
        realign     = iPSync && (byte_cnt != 8'd0);
        is_sync     = iPSync || (byte_cnt == 8'd0);
        gs_pos      = (pkt_cnt == 4'd0);
        // The receiver trusts an inverted sync over its own packet count.
        force_gs    = iMode && (iData == GS_MARK);
        group_start = is_sync && (iMode ? force_gs : gs_pos);
        gs_miss     = is_sync && iMode && gs_pos && !force_gs;
    end

    always_comb begin
        prbs_nxt   = prbs;
        byte_nxt   = byte_cnt;
        pkt_nxt    = pkt_cnt;
        data_nxt   = data_p1;
        gstart_nxt = 1'b0;
        err_nxt    = 1'b0;
        if (iValid) begin
            if (iCheck) begin
                data_nxt = 8'h00;
            end else begin
                if (is_sync) begin
                    byte_nxt = 8'd1;
                end else if (byte_cnt == LAST_BYTE) begin
                    byte_nxt = 8'd0;
                end else begin
                    byte_nxt = byte_cnt + 8'd1;
                end
                err_nxt = flywheel || realign || gs_miss;
                if (group_start) begin
                    prbs_nxt   = INIT_SEED;
                    pkt_nxt    = 4'd1;
                    gstart_nxt = 1'b1;
                    data_nxt   = ~iData;
                end else begin
                    prbs_nxt = {prbs[7:1], ks};
                    data_nxt = is_sync ? iData : (iData ^ ks);
                    if (is_sync) begin
                        pkt_nxt = (pkt_cnt == LAST_PKT) ? 4'd0 : pkt_cnt + 4'd1;
                    end
                end
                if (iBypass) begin
                    data_nxt = iData;
                end
            end
        end
    end

    // Stage p1: single register stage between input byte and output byte.
    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            prbs      <= INIT_SEED;
            byte_cnt  <= 8'd0;
            pkt_cnt   <= 4'd0;
            data_p1   <= 8'h00;
            vld_p1    <= 1'b0;
            psync_p1  <= 1'b0;
            check_p1  <= 1'b0;
            gstart_p1 <= 1'b0;
            err_p1    <= 1'b0;
        end else begin
            prbs      <= prbs_nxt;
            byte_cnt  <= byte_nxt;
            pkt_cnt   <= pkt_nxt;
            data_p1   <= data_nxt;
            vld_p1    <= iValid;
            psync_p1  <= iValid && iPSync;
            check_p1  <= iValid && iCheck;
            gstart_p1 <= gstart_nxt;
            err_p1    <= err_nxt;
        end
    end

    assign oData       = data_p1;
    assign oValid      = vld_p1;
    assign oPSync      = psync_p1;
    assign oCheck      = check_p1;
    assign oGroupStart = gstart_p1;
    assign oSyncErr    = err_p1;

endmodule

// File: tb/tb_sync_group_randomizer.sv
// Directed bench for sync_group_randomizer: keystream comes from an independent bit-serial
// 1+x^14+x^15 generator; sync, flywheel, realign, check, bypass and reset cases are hand-sequenced.
module tb_sync_group_randomizer;

    logic       iClk = 1'b0;
    logic       iClrn = 1'b0;
    logic       iValid = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iPSync = 1'b0;
    logic       iCheck = 1'b0;
    logic       iMode = 1'b0;
    logic       iBypass = 1'b0;
    logic [7:0] oData;
    logic       oValid, oPSync, oCheck, oGroupStart, oSyncErr;

    int checks = 0;
    int failures = 0;
    int ki = 0;
    logic [7:0] ks_ref [0:1599];
    logic [7:0] orig [0:1691];
    logic [7:0] captured [0:1691];

    sync_group_randomizer dut (
        .iClk(iClk), .iClrn(iClrn), .iValid(iValid), .iData(iData), .iPSync(iPSync),
        .iCheck(iCheck), .iMode(iMode), .iBypass(iBypass), .oData(oData), .oValid(oValid),
        .oPSync(oPSync), .oCheck(oCheck), .oGroupStart(oGroupStart), .oSyncErr(oSyncErr)
    );

    always #5 iClk = ~iClk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pk(input logic v, input logic ps, input logic ck,
                                       input logic gs, input logic er, input logic [7:0] d);
        return {3'b000, v, ps, ck, gs, er, d};
    endfunction

    function automatic logic [15:0] obs_w();
        return {3'b000, oValid, oPSync, oCheck, oGroupStart, oSyncErr, oData};
    endfunction

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic ps, input logic ck);
        iValid = 1'b1;
        iData  = d;
        iPSync = ps;
        iCheck = ck;
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_cycle();
        iValid = 1'b0;
        iData  = 8'h00;
        iPSync = 1'b0;
        iCheck = 1'b0;
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iValid = 1'b0;
        iPSync = 1'b0;
        iCheck = 1'b0;
        iClrn  = 1'b0;
        @(posedge iClk);
        #1;
        chk("reset_state", obs_w(), pk(0, 0, 0, 0, 0, 8'h00));
        iClrn = 1'b1;
        ki = 0;
    endtask

    task automatic sync_byte(input string tag, input logic [7:0] d, input logic ps,
                             input logic gs, input logic er, input logic [7:0] e);
        drive(d, ps, 1'b0);
        chk(tag, obs_w(), pk(1, ps, 0, gs, er, e));
        if (gs) ki = 0;
        else ki++;
    endtask

    task automatic payload(input int n, input bit rnd, input bit byp);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? 8'($urandom) : 8'h00;
            drive(d, 1'b0, 1'b0);
            chk("payload", obs_w(), pk(1, 0, 0, 0, 0, byp ? d : (d ^ ks_ref[ki])));
            ki++;
        end
    endtask

    task automatic group_pkt(input bit gs);
        sync_byte("sync", 8'h47, 1'b1, gs, 1'b0, gs ? 8'hB8 : 8'h47);
        payload(187, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:1] s;
        logic [7:0]  kb;
        logic        nb;
        int          idx;

        s = 15'b000000010101001;
        for (int k = 0; k < 1600; k++) begin
            kb = 8'h00;
            for (int b = 0; b < 8; b++) begin
                nb = s[14] ^ s[15];
                s  = {s[14:1], nb};
                kb = {kb[6:0], nb};
            end
            ks_ref[k] = kb;
        end

        // Reset holds outputs low even with active-looking inputs.
        iValid = 1'b1; iData = 8'hFF; iPSync = 1'b1; iCheck = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        chk("reset_hold", obs_w(), pk(0, 0, 0, 0, 0, 8'h00));
        do_reset();

        // Mode 0: 16 packets, zero payload.
        sync_byte("gs_first", 8'h47, 1'b1, 1'b1, 1'b0, 8'hB8);
        drive(8'h00, 1'b0, 1'b0);
        chk("ks_first", obs_w(), pk(1, 0, 0, 0, 0, 8'h03));
        drive(8'h00, 1'b0, 1'b0);
        chk("ks_second", obs_w(), pk(1, 0, 0, 0, 0, 8'hF6));
        ki = 2;
        payload(185, 1'b0, 1'b0);
        for (int p = 1; p < 16; p++) group_pkt(p % 8 == 0);

        // Mode 0 then mode 1 on the same stream must give back the original.
        do_reset();
        idx = 0;
        for (int p = 0; p < 9; p++) begin
            for (int b = 0; b < 188; b++) begin
                orig[idx] = (b == 0) ? 8'h47 : 8'($urandom);
                drive(orig[idx], b == 0, 1'b0);
                captured[idx] = oData;
                idx++;
            end
        end
        do_reset();
        iMode = 1'b1;
        idx = 0;
        for (int p = 0; p < 9; p++) begin
            for (int b = 0; b < 188; b++) begin
                drive(captured[idx], b == 0, 1'b0);
                chk("chain", obs_w(), pk(1, b == 0, 0, (b == 0) && (p % 8 == 0), 0, orig[idx]));
                idx++;
            end
        end
        iMode = 1'b0;

        // Missing sync on packet 3: flywheel inserts it.
        do_reset();
        group_pkt(1'b1);
        group_pkt(1'b0);
        group_pkt(1'b0);
        sync_byte("flywheel", 8'h47, 1'b0, 1'b0, 1'b1, 8'h47);
        payload(187, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) group_pkt(1'b0);
        sync_byte("fly_gs", 8'h47, 1'b1, 1'b1, 1'b0, 8'hB8);
        payload(20, 1'b0, 1'b0);

        // Early sync at byte 100 realigns.
        do_reset();
        group_pkt(1'b1);
        sync_byte("sync", 8'h47, 1'b1, 1'b0, 1'b0, 8'h47);
        payload(99, 1'b0, 1'b0);
        sync_byte("realign", 8'h47, 1'b1, 1'b0, 1'b1, 8'h47);
        payload(187, 1'b0, 1'b0);
        for (int p = 0; p < 5; p++) group_pkt(1'b0);
        sync_byte("realign_gs", 8'h47, 1'b1, 1'b1, 1'b0, 8'hB8);
        payload(10, 1'b0, 1'b0);

        // Check bytes mid-payload freeze PRBS and counters.
        do_reset();
        sync_byte("gs", 8'h47, 1'b1, 1'b1, 1'b0, 8'hB8);
        payload(20, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(8'h5A, 1'b0, 1'b1);
            chk("check_byte", obs_w(), pk(1, 0, 1, 0, 0, 8'h00));
        end
        drive(8'h47, 1'b1, 1'b1);
        chk("check_over_sync", obs_w(), pk(1, 1, 1, 0, 0, 8'h00));
        payload(167, 1'b0, 1'b0);
        group_pkt(1'b0);

        // Idle cycles hold state; bypass keeps PRBS and counters running.
        sync_byte("sync", 8'h47, 1'b1, 1'b0, 1'b0, 8'h47);
        payload(10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            chk("idle_hold", obs_w(), pk(0, 0, 0, 0, 0, ks_ref[ki - 1]));
        end
        payload(5, 1'b0, 1'b0);
        iBypass = 1'b1;
        payload(10, 1'b1, 1'b1);
        drive(8'hC3, 1'b0, 1'b1);
        chk("bypass_check", obs_w(), pk(1, 0, 1, 0, 0, 8'h00));
        payload(162, 1'b1, 1'b1);
        for (int p = 0; p < 5; p++) begin
            sync_byte("bypass_sync", 8'h47, 1'b1, 1'b0, 1'b0, 8'h47);
            payload(187, 1'b0, 1'b1);
        end
        sync_byte("bypass_gs", 8'h47, 1'b1, 1'b1, 1'b0, 8'h47);
        iBypass = 1'b0;
        payload(187, 1'b0, 1'b0);

        // Mode 1: group-start position without the inverted mark, then a forced group start.
        do_reset();
        iMode = 1'b1;
        sync_byte("rx_gs_miss", 8'h47, 1'b1, 1'b0, 1'b1, 8'h47);
        drive(8'h00, 1'b0, 1'b0);
        chk("rx_no_reload", obs_w(), pk(1, 0, 0, 0, 0, 8'hF6));
        ki = 2;
        payload(186, 1'b1, 1'b0);
        sync_byte("rx_force_gs", 8'hB8, 1'b1, 1'b1, 1'b0, 8'h47);
        drive(8'h00, 1'b0, 1'b0);
        chk("rx_reload", obs_w(), pk(1, 0, 0, 0, 0, 8'h03));
        iMode = 1'b0;

        // Reset at byte 50 of packet 5.
        do_reset();
        for (int p = 0; p < 5; p++) group_pkt(p == 0);
        sync_byte("sync", 8'h47, 1'b1, 1'b0, 1'b0, 8'h47);
        payload(49, 1'b0, 1'b0);
        iValid = 1'b1; iData = 8'h00; iPSync = 1'b0; iCheck = 1'b0;
        #2;
        iClrn = 1'b0;
        #1;
        chk("rst_async", obs_w(), pk(0, 0, 0, 0, 0, 8'h00));
        @(posedge iClk);
        #1;
        chk("rst_edge", obs_w(), pk(0, 0, 0, 0, 0, 8'h00));
        iValid = 1'b0;
        iClrn = 1'b1;
        ki = 0;
        sync_byte("rst_gs", 8'h47, 1'b1, 1'b1, 1'b0, 8'hB8);
        drive(8'h00, 1'b0, 1'b0);
        chk("rst_ks", obs_w(), pk(1, 0, 0, 0, 0, 8'h03));
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
